// File: rtl/cpu_sequencer_if.sv
// Program-memory fetch bus between cpu_sequencer (master) and program memory (slave).
interface cpu_sequencer_if #(
    parameter int AW = 4
);
    logic [AW-1:0] mem_addr;
    logic          mem_req;
    logic          mem_ack;
    logic [2:0]    Opcode;

    modport master (output mem_addr, output mem_req, input mem_ack, input Opcode);
    modport slave  (input mem_addr, input mem_req, output mem_ack, output Opcode);
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control unit for the X/Y/Z/ULA accumulator datapath.
// Optional macro SEQ_OVF_TRAP_EN: ADD/SUB overflow in EXEC halts instead of continuing.
module cpu_sequencer #(
    parameter int AW          = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    cpu_sequencer_if.master       mem,
    input  logic                  status,
    output logic [2:0]            Tx,
    output logic [2:0]            Ty,
    output logic [2:0]            Tz,
    output logic [2:0]            tula,
    output logic                  busy,
    output logic                  done,
    output logic                  fault,
    output logic                  ovf
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALTED} state_e;
    typedef enum logic [2:0] {OP_NOP, OP_LDX, OP_ADD, OP_SUB, OP_AND, OP_MOVY, OP_OUT, OP_HALT} op_e;
    typedef enum logic [2:0] {R_HOLD, R_LOAD, R_CLEAR, R_SHL, R_SHR} reg_e;
    typedef enum logic [2:0] {U_ADD, U_SUB, U_AND, U_OR, U_XOR, U_PASSX} ula_e;

    localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

    state_e        state_q, state_d;
    op_e           ir_q, ir_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [7:0]    wait_q, wait_d;
    logic [2:0]    tx_q, tx_d, ty_q, ty_d, tz_q, tz_d, tula_q, tula_d;
    logic          req_q, req_d, busy_q, busy_d, done_q, done_d;
    logic          fault_q, fault_d, ovf_q, ovf_d;

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        wait_d  = wait_q;
        fault_d = fault_q;
        ovf_d   = ovf_q;
        tx_d    = R_HOLD;
        ty_d    = R_HOLD;
        tz_d    = R_HOLD;
        tula_d  = U_ADD;

        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    wait_d  = '0;
                    fault_d = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            S_FETCH: begin
                // ack on the final allowed cycle still wins over the timeout
                if (mem.mem_ack) begin
                    ir_d    = op_e'(mem.Opcode);
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    fault_d = 1'b1;
                    state_d = S_HALTED;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (ir_q == OP_HALT) begin
                    state_d = S_HALTED;
                end else if (ir_q == OP_NOP) begin
                    pc_d    = pc_q + AW'(1);
                    wait_d  = '0;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                    // codes are registered here so they are valid for the whole EXEC cycle
                    case (ir_q)
                        OP_LDX:  tx_d = R_LOAD;
                        OP_ADD:  begin ty_d = R_LOAD; tula_d = U_ADD;   end
                        OP_SUB:  begin ty_d = R_LOAD; tula_d = U_SUB;   end
                        OP_AND:  begin ty_d = R_LOAD; tula_d = U_AND;   end
                        OP_MOVY: begin ty_d = R_LOAD; tula_d = U_PASSX; end
                        OP_OUT:  tz_d = R_LOAD;
                        default: ;
                    endcase
                end
            end
            S_EXEC: begin
                pc_d    = pc_q + AW'(1);
                wait_d  = '0;
                state_d = S_FETCH;
                if ((ir_q == OP_ADD || ir_q == OP_SUB) && status) begin
                    ovf_d = 1'b1;
`ifdef SEQ_OVF_TRAP_EN
                    state_d = S_HALTED;
`else
                    state_d = S_FETCH;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_d  = (state_d == S_FETCH);
    assign busy_d = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_EXEC);
    assign done_d = (state_d == S_HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ir_q    <= OP_NOP;
            pc_q    <= '0;
            wait_q  <= '0;
            tx_q    <= '0;
            ty_q    <= '0;
            tz_q    <= '0;
            tula_q  <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            wait_q  <= wait_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            tz_q    <= tz_d;
            tula_q  <= tula_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            ovf_q   <= ovf_d;
        end
    end

    assign mem.mem_addr = pc_q;
    assign mem.mem_req  = req_q;
    assign Tx    = tx_q;
    assign Ty    = ty_q;
    assign Tz    = tz_q;
    assign tula  = tula_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign fault = fault_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a 4-bit-address instance plus a 2-bit-address instance for pc wrap.
module tb_cpu_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic status = 1'b0;
    logic ack_en = 1'b0;
    logic [2:0] prog [16];

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cpu_sequencer_if #(.AW(4)) bus4 ();
    cpu_sequencer_if #(.AW(2)) bus2 ();

    assign bus4.Opcode  = prog[bus4.mem_addr];
    assign bus4.mem_ack = ack_en;
    assign bus2.Opcode  = 3'd1;
    assign bus2.mem_ack = 1'b1;

    logic [2:0] tx4, ty4, tz4, tula4, tx2, ty2, tz2, tula2;
    logic busy4, done4, fault4, ovf4, busy2, done2, fault2, ovf2;

    cpu_sequencer #(.AW(4), .ACK_TIMEOUT(15)) u_dut (
        .clk(clk), .rst(rst), .start(start), .mem(bus4), .status(status),
        .Tx(tx4), .Ty(ty4), .Tz(tz4), .tula(tula4),
        .busy(busy4), .done(done4), .fault(fault4), .ovf(ovf4)
    );

    cpu_sequencer #(.AW(2), .ACK_TIMEOUT(15)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .mem(bus2), .status(status),
        .Tx(tx2), .Ty(ty2), .Tz(tz2), .tula(tula2),
        .busy(busy2), .done(done2), .fault(fault2), .ovf(ovf2)
    );

    logic [11:0] ctl4;
    logic [4:0]  flg4;
    assign ctl4 = {tx4, ty4, tz4, tula4};
    assign flg4 = {bus4.mem_req, busy4, done4, fault4, ovf4};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog(input logic [2:0] p0, input logic [2:0] p1,
                             input logic [2:0] p2, input logic [2:0] p3);
        for (int i = 0; i < 16; i++) prog[i] = 3'd0;
        prog[0] = p0; prog[1] = p1; prog[2] = p2; prog[3] = p3;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        status = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        load_prog(3'd1, 3'd1, 3'd1, 3'd1);
        ack_en = 1'b1;
        do_reset();
        n_cmp++;
        if ({ctl4, flg4, bus4.mem_addr} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset got=%h exp=%h", {ctl4, flg4, bus4.mem_addr}, 21'd0);
        end
    endtask

    task automatic test_basic();
        logic [11:0] ec;
        logic [4:0]  ef;
        logic [3:0]  ea;
        load_prog(3'd1, 3'd2, 3'd6, 3'd7);
        ack_en = 1'b1;
        do_reset();
        start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            start = 1'b0;
            ec = '0;
            if (k == 3) ec = {3'd1, 9'd0};
            if (k == 6) ec = {3'd0, 3'd1, 6'd0};
            if (k == 9) ec = {6'd0, 3'd1, 3'd0};
            ef = (k == 12) ? 5'b00100 : (((k % 3) == 1) ? 5'b11000 : 5'b01000);
            n_cmp++;
            if ({ctl4, flg4} !== {ec, ef}) begin
                n_fail++;
                $display("FAIL basic cyc=%0d got=%h exp=%h", k, {ctl4, flg4}, {ec, ef});
            end
            if ((k % 3) == 1 && k < 12) begin
                ea = 4'((k - 1) / 3);
                n_cmp++;
                if (bus4.mem_addr !== ea) begin
                    n_fail++;
                    $display("FAIL basic_addr cyc=%0d got=%0d exp=%0d", k, bus4.mem_addr, ea);
                end
            end
        end
        n_cmp++;
        if (bus4.mem_addr !== 4'd3) begin
            n_fail++;
            $display("FAIL basic_halt_pc got=%0d exp=3", bus4.mem_addr);
        end
    endtask

    task automatic test_nop();
        load_prog(3'd0, 3'd0, 3'd7, 3'd1);
        ack_en = 1'b1;
        do_reset();
        start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            start = 1'b0;
            n_cmp++;
            if ({ctl4, done4} !== {12'd0, (k == 7)}) begin
                n_fail++;
                $display("FAIL nop cyc=%0d got=%h exp=%h", k, {ctl4, done4}, {12'd0, (k == 7)});
            end
        end
        n_cmp++;
        if (bus4.mem_addr !== 4'd2) begin
            n_fail++;
            $display("FAIL nop_pc got=%0d exp=2", bus4.mem_addr);
        end
    endtask

    task automatic test_timeout();
        load_prog(3'd1, 3'd1, 3'd1, 3'd1);
        ack_en = 1'b0;
        do_reset();
        start = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step();
            start = 1'b0;
            n_cmp++;
            if (flg4 !== 5'b11000) begin
                n_fail++;
                $display("FAIL timeout_wait cyc=%0d got=%b exp=11000", k, flg4);
            end
        end
        step();
        n_cmp++;
        if (flg4 !== 5'b00110) begin
            n_fail++;
            $display("FAIL timeout_fault got=%b exp=00110", flg4);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++;
        if (flg4 !== 5'b11000) begin
            n_fail++;
            $display("FAIL timeout_restart got=%b exp=11000", flg4);
        end

        do_reset();
        ack_en = 1'b0;
        start = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step();
            start = 1'b0;
            if (k == 15) ack_en = 1'b1;
        end
        step();
        n_cmp++;
        if (flg4 !== 5'b01000) begin
            n_fail++;
            $display("FAIL late_ack_decode got=%b exp=01000", flg4);
        end
        step();
        ack_en = 1'b0;
        n_cmp++;
        if (ctl4 !== {3'd1, 9'd0}) begin
            n_fail++;
            $display("FAIL late_ack_exec got=%h exp=%h", ctl4, {3'd1, 9'd0});
        end
        for (int k = 18; k <= 32; k++) step();
        n_cmp++;
        if (flg4 !== 5'b11000) begin
            n_fail++;
            $display("FAIL wait_cleared got=%b exp=11000", flg4);
        end
        step();
        n_cmp++;
        if (flg4 !== 5'b00110) begin
            n_fail++;
            $display("FAIL second_timeout got=%b exp=00110", flg4);
        end
    endtask

    task automatic test_ovf();
        load_prog(3'd2, 3'd7, 3'd0, 3'd0);
        ack_en = 1'b1;
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        status = 1'b1;
        step();
        step();
        n_cmp++;
        if ({ctl4, flg4} !== {3'd0, 3'd1, 3'd0, 3'd0, 5'b01000}) begin
            n_fail++;
            $display("FAIL ovf_exec got=%h exp=%h", {ctl4, flg4}, {3'd0, 3'd1, 3'd0, 3'd0, 5'b01000});
        end
        step();
        status = 1'b0;
`ifdef SEQ_OVF_TRAP_EN
        n_cmp++;
        if ({flg4, bus4.mem_addr} !== {5'b00101, 4'd1}) begin
            n_fail++;
            $display("FAIL ovf_trap got=%h exp=%h", {flg4, bus4.mem_addr}, {5'b00101, 4'd1});
        end
`else
        n_cmp++;
        if ({flg4, bus4.mem_addr} !== {5'b11001, 4'd1}) begin
            n_fail++;
            $display("FAIL ovf_continue got=%h exp=%h", {flg4, bus4.mem_addr}, {5'b11001, 4'd1});
        end
        step();
        step();
        n_cmp++;
        if ({flg4, bus4.mem_addr} !== {5'b00101, 4'd1}) begin
            n_fail++;
            $display("FAIL ovf_sticky got=%h exp=%h", {flg4, bus4.mem_addr}, {5'b00101, 4'd1});
        end
`endif
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++;
        if ({flg4, bus4.mem_addr} !== {5'b11000, 4'd0}) begin
            n_fail++;
            $display("FAIL ovf_clear got=%h exp=%h", {flg4, bus4.mem_addr}, {5'b11000, 4'd0});
        end
    endtask

    task automatic test_rst_exec();
        load_prog(3'd1, 3'd1, 3'd7, 3'd0);
        ack_en = 1'b1;
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        n_cmp++;
        if ({ctl4, flg4} !== {3'd1, 9'd0, 5'b01000}) begin
            n_fail++;
            $display("FAIL rst_pre got=%h exp=%h", {ctl4, flg4}, {3'd1, 9'd0, 5'b01000});
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({ctl4, flg4, bus4.mem_addr} !== 21'd0) begin
            n_fail++;
            $display("FAIL rst_exec got=%h exp=%h", {ctl4, flg4, bus4.mem_addr}, 21'd0);
        end

        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        n_cmp++;
        if ({flg4, bus4.mem_addr} !== {5'b11000, 4'd1}) begin
            n_fail++;
            $display("FAIL busy_fetch got=%h exp=%h", {flg4, bus4.mem_addr}, {5'b11000, 4'd1});
        end
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++;
        if ({flg4, bus4.mem_addr} !== {5'b01000, 4'd1}) begin
            n_fail++;
            $display("FAIL start_ignored got=%h exp=%h", {flg4, bus4.mem_addr}, {5'b01000, 4'd1});
        end
        step();
        n_cmp++;
        if (ctl4 !== {3'd1, 9'd0}) begin
            n_fail++;
            $display("FAIL start_ignored_exec got=%h exp=%h", ctl4, {3'd1, 9'd0});
        end
    endtask

    task automatic test_wrap();
        logic [1:0] ea;
        do_reset();
        start = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step();
            start = 1'b0;
            if ((k % 3) == 1) begin
                ea = 2'((k - 1) / 3);
                n_cmp++;
                if ({bus2.mem_req, bus2.mem_addr} !== {1'b1, ea}) begin
                    n_fail++;
                    $display("FAIL wrap_addr cyc=%0d got=%h exp=%h", k, {bus2.mem_req, bus2.mem_addr}, {1'b1, ea});
                end
            end
        end
        n_cmp++;
        if ({tx2, busy2, done2} !== {3'd1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_exec got=%h exp=%h", {tx2, busy2, done2}, {3'd1, 1'b1, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nop();
        test_timeout();
        test_ovf();
        test_rst_exec();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
